// File: rtl/calc3_port_responder.sv
`default_nettype none
// ============================================================================
// Module  : calc3_port_responder
// Brief   : Single-port calc3 responder, 16x32 register file, fixed-latency
//           tagged responses with busy-tag tracking.
// Revision: 1.0
// ============================================================================
module calc3_port_responder #(
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  reqx_cmd,
    input  logic [31:0] reqx_data,
    input  logic [3:0]  reqx_d1,
    input  logic [3:0]  reqx_d2,
    input  logic [3:0]  reqx_r1,
    input  logic [1:0]  reqx_tag,
    output logic [1:0]  outx_resp,
    output logic [1:0]  outx_tag,
    output logic [31:0] outx_data
);

    localparam logic [3:0] C_CMD_NONE  = 4'd0;
    localparam logic [3:0] C_CMD_ADD   = 4'd1;
    localparam logic [3:0] C_CMD_SUB   = 4'd2;
    localparam logic [3:0] C_CMD_SHL   = 4'd5;
    localparam logic [3:0] C_CMD_SHR   = 4'd6;
    localparam logic [3:0] C_CMD_STORE = 4'd12;
    localparam logic [3:0] C_CMD_FETCH = 4'd13;

    localparam logic [1:0] C_RESP_NONE = 2'd0;
    localparam logic [1:0] C_RESP_OK   = 2'd1;
    localparam logic [1:0] C_RESP_ERR  = 2'd2;

    logic [31:0] rf_q [16];
    logic [3:0]  busy_q;
    logic [3:0]  busy_d;

    logic [1:0]  pipe_resp_q   [LATENCY];
    logic [1:0]  pipe_tag_q    [LATENCY];
    logic [31:0] pipe_data_q   [LATENCY];
    logic        pipe_tagged_q [LATENCY];

    logic [1:0]  out_resp_q;
    logic [1:0]  out_tag_q;
    logic [31:0] out_data_q;

    logic        req_w;
    logic [31:0] src1_w;
    logic [31:0] src2_w;
    logic [32:0] sum_w;
    logic [3:0]  clr_w;
    logic [3:0]  busy_eff_w;
    logic        tag_busy_w;

    logic [1:0]  exe_resp_d;
    logic [31:0] exe_data_d;
    logic        exe_tagged_d;
    logic        wr_en_d;
    logic [31:0] wr_data_d;

    assign req_w  = (reqx_cmd != C_CMD_NONE);
    assign src1_w = rf_q[reqx_d1];
    assign src2_w = rf_q[reqx_d2];
    assign sum_w  = {1'b0, src1_w} + {1'b0, src2_w};

    // The slot about to be driven frees its tag now, so a same-cycle reuse sees it clear.
    assign clr_w      = pipe_tagged_q[LATENCY-1] ? (4'b0001 << pipe_tag_q[LATENCY-1]) : 4'b0000;
    assign busy_eff_w = busy_q & ~clr_w;
    assign tag_busy_w = busy_eff_w[reqx_tag];

    always_comb begin
        exe_resp_d   = C_RESP_NONE;
        exe_data_d   = 32'd0;
        exe_tagged_d = 1'b0;
        wr_en_d      = 1'b0;
        wr_data_d    = 32'd0;
        busy_d       = busy_eff_w;
        if (req_w) begin
            if (tag_busy_w) begin
                exe_resp_d = C_RESP_ERR;
            end else begin
                exe_tagged_d     = 1'b1;
                busy_d[reqx_tag] = 1'b1;
                exe_resp_d       = C_RESP_OK;
                case (reqx_cmd)
                    C_CMD_ADD: begin
                        if (sum_w[32]) begin
                            exe_resp_d = C_RESP_ERR;
                        end else begin
                            wr_en_d    = 1'b1;
                            wr_data_d  = sum_w[31:0];
                            exe_data_d = sum_w[31:0];
                        end
                    end
                    C_CMD_SUB: begin
                        if (src1_w < src2_w) begin
                            exe_resp_d = C_RESP_ERR;
                        end else begin
                            wr_en_d    = 1'b1;
                            wr_data_d  = src1_w - src2_w;
                            exe_data_d = src1_w - src2_w;
                        end
                    end
                    C_CMD_SHL: begin
                        wr_en_d    = 1'b1;
                        wr_data_d  = src1_w << src2_w[4:0];
                        exe_data_d = src1_w << src2_w[4:0];
                    end
                    C_CMD_SHR: begin
                        wr_en_d    = 1'b1;
                        wr_data_d  = src1_w >> src2_w[4:0];
                        exe_data_d = src1_w >> src2_w[4:0];
                    end
                    C_CMD_STORE: begin
                        wr_en_d   = 1'b1;
                        wr_data_d = reqx_data;
                    end
                    C_CMD_FETCH: begin
                        exe_data_d = src1_w;
                    end
                    default: begin
                        exe_resp_d = C_RESP_ERR;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= 32'd0;
            end
            for (int i = 0; i < LATENCY; i++) begin
                pipe_resp_q[i]   <= C_RESP_NONE;
                pipe_tag_q[i]    <= 2'd0;
                pipe_data_q[i]   <= 32'd0;
                pipe_tagged_q[i] <= 1'b0;
            end
            busy_q     <= 4'd0;
            out_resp_q <= C_RESP_NONE;
            out_tag_q  <= 2'd0;
            out_data_q <= 32'd0;
        end else begin
            if (wr_en_d) begin
                rf_q[reqx_r1] <= wr_data_d;
            end
            busy_q           <= busy_d;
            pipe_resp_q[0]   <= exe_resp_d;
            pipe_tag_q[0]    <= req_w ? reqx_tag : 2'd0;
            pipe_data_q[0]   <= exe_data_d;
            pipe_tagged_q[0] <= exe_tagged_d;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_resp_q[i]   <= pipe_resp_q[i-1];
                pipe_tag_q[i]    <= pipe_tag_q[i-1];
                pipe_data_q[i]   <= pipe_data_q[i-1];
                pipe_tagged_q[i] <= pipe_tagged_q[i-1];
            end
            out_resp_q <= pipe_resp_q[LATENCY-1];
            out_tag_q  <= pipe_tag_q[LATENCY-1];
            out_data_q <= pipe_data_q[LATENCY-1];
        end
    end

    assign outx_resp = out_resp_q;
    assign outx_tag  = out_tag_q;
    assign outx_data = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_calc3_port_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_calc3_port_responder
// Brief   : Scoreboard bench for calc3_port_responder using directed vectors.
// Revision: 1.0
// ============================================================================
module tb_calc3_port_responder;

    localparam int LATENCY = 3;

    localparam logic [3:0] ADD = 4'd1, SUB = 4'd2, SHL = 4'd5, SHR = 4'd6,
                           STO = 4'd12, FET = 4'd13;

    typedef struct {
        logic [1:0]  resp;
        logic [1:0]  tag;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  reqx_cmd = 4'd0;
    logic [31:0] reqx_data = 32'd0;
    logic [3:0]  reqx_d1 = 4'd0;
    logic [3:0]  reqx_d2 = 4'd0;
    logic [3:0]  reqx_r1 = 4'd0;
    logic [1:0]  reqx_tag = 2'd0;
    logic [1:0]  outx_resp;
    logic [1:0]  outx_tag;
    logic [31:0] outx_data;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    calc3_port_responder #(.LATENCY(LATENCY)) dut (
        .clk       (clk),
        .reset     (reset),
        .reqx_cmd  (reqx_cmd),
        .reqx_data (reqx_data),
        .reqx_d1   (reqx_d1),
        .reqx_d2   (reqx_d2),
        .reqx_r1   (reqx_r1),
        .reqx_tag  (reqx_tag),
        .outx_resp (outx_resp),
        .outx_tag  (outx_tag),
        .outx_data (outx_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard whenever a response appears, checks idle cycles.
    always @(negedge clk) begin
        exp_t e;
        if (outx_resp != 2'd0) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_resp cyc=%0d got resp=%0d tag=%0d data=%h, required no response",
                         cyc, outx_resp, outx_tag, outx_data);
            end else begin
                e = sb.pop_front();
                if (outx_resp !== e.resp || outx_tag !== e.tag || outx_data !== e.data || cyc != e.due) begin
                    n_bad++;
                    $display("FAIL response cyc=%0d got resp=%0d tag=%0d data=%h, required resp=%0d tag=%0d data=%h at cyc=%0d",
                             cyc, outx_resp, outx_tag, outx_data, e.resp, e.tag, e.data, e.due);
                end
            end
        end else begin
            n_vec++;
            if (outx_tag !== 2'd0 || outx_data !== 32'd0) begin
                n_bad++;
                $display("FAIL idle_outputs cyc=%0d got tag=%0d data=%h, required tag=0 data=0",
                         cyc, outx_tag, outx_data);
            end
            if (sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                n_bad++;
                $display("FAIL missing_resp cyc=%0d got resp=0, required resp=%0d tag=%0d data=%h at cyc=%0d",
                         cyc, e.resp, e.tag, e.data, e.due);
            end
        end
    end

    task automatic issue(input logic [3:0] cmd, input logic [3:0] d1, input logic [3:0] d2,
                         input logic [3:0] r1, input logic [31:0] data, input logic [1:0] tag,
                         input logic [1:0] er, input logic [31:0] ed);
        exp_t e;
        @(negedge clk);
        reqx_cmd  = cmd;
        reqx_d1   = d1;
        reqx_d2   = d2;
        reqx_r1   = r1;
        reqx_data = data;
        reqx_tag  = tag;
        e.resp = er;
        e.tag  = tag;
        e.data = ed;
        e.due  = cyc + 1 + LATENCY;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            reqx_cmd = 4'd0;
        end
    endtask

    // A store is presented throughout reset; it must leave no trace.
    task automatic apply_reset(input int n);
        @(negedge clk);
        sb.delete();
        reset     = 1'b0;
        reqx_cmd  = STO;
        reqx_r1   = 4'd4;
        reqx_data = 32'hDEAD_BEEF;
        reqx_tag  = 2'd3;
        repeat (n) @(negedge clk);
        reset    = 1'b1;
        reqx_cmd = 4'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        apply_reset(2);

        // Reset state
        issue(FET, 4'd5, 4'd0, 4'd0, 32'd0, 2'd1, 2'd1, 32'd0);
        issue(FET, 4'd4, 4'd0, 4'd0, 32'd0, 2'd2, 2'd1, 32'd0);
        idle(4);

        // Store / add overflow
        issue(STO, 4'd0, 4'd0, 4'd1, 32'hFFFF_FFFF, 2'd0, 2'd1, 32'd0);
        issue(STO, 4'd0, 4'd0, 4'd2, 32'h0000_0001, 2'd1, 2'd1, 32'd0);
        issue(ADD, 4'd1, 4'd2, 4'd3, 32'd0,          2'd2, 2'd2, 32'd0);
        issue(FET, 4'd3, 4'd0, 4'd0, 32'd0,          2'd3, 2'd1, 32'd0);
        idle(4);

        // Sub and shifts, with tags reused exactly LATENCY+1 cycles later
        issue(STO, 4'd0, 4'd0, 4'd4, 32'd10,   2'd0, 2'd1, 32'd0);
        issue(STO, 4'd0, 4'd0, 4'd5, 32'd3,    2'd1, 2'd1, 32'd0);
        issue(SUB, 4'd4, 4'd5, 4'd6, 32'd0,    2'd2, 2'd1, 32'd7);
        issue(SUB, 4'd5, 4'd4, 4'd6, 32'd0,    2'd3, 2'd2, 32'd0);
        issue(FET, 4'd6, 4'd0, 4'd0, 32'd0,    2'd0, 2'd1, 32'd7);
        issue(SHL, 4'd4, 4'd5, 4'd7, 32'd0,    2'd1, 2'd1, 32'd80);
        issue(STO, 4'd0, 4'd0, 4'd5, 32'h23,   2'd2, 2'd1, 32'd0);
        issue(SHR, 4'd4, 4'd5, 4'd8, 32'd0,    2'd3, 2'd1, 32'd1);
        issue(FET, 4'd8, 4'd0, 4'd0, 32'd0,    2'd0, 2'd1, 32'd1);
        idle(4);

        // Busy tag: reuse at N+1 errors, reuse at N+3 succeeds
        issue(FET, 4'd4, 4'd0, 4'd0, 32'd0,    2'd2, 2'd1, 32'd10);
        issue(STO, 4'd0, 4'd0, 4'd9, 32'h55,   2'd2, 2'd2, 32'd0);
        idle(1);
        issue(FET, 4'd9, 4'd0, 4'd0, 32'd0,    2'd2, 2'd1, 32'd0);
        idle(4);

        // Reuse at N+2 is still one cycle too early
        issue(FET, 4'd4, 4'd0, 4'd0, 32'd0,    2'd1, 2'd1, 32'd10);
        idle(1);
        issue(FET, 4'd4, 4'd0, 4'd0, 32'd0,    2'd1, 2'd2, 32'd0);
        idle(4);

        // Invalid command, then read-after-write hazard
        issue(4'd7, 4'd0, 4'd0, 4'd10, 32'd0,  2'd0, 2'd2, 32'd0);
        issue(STO, 4'd0, 4'd0, 4'd1, 32'd5,    2'd1, 2'd1, 32'd0);
        issue(ADD, 4'd1, 4'd1, 4'd1, 32'd0,    2'd2, 2'd1, 32'd10);
        issue(FET, 4'd10, 4'd0, 4'd0, 32'd0,   2'd3, 2'd1, 32'd0);
        idle(4);

        // Reset mid-operation drops in-flight responses and frees all tags
        issue(STO, 4'd0, 4'd0, 4'd1, 32'h11,   2'd0, 2'd1, 32'd0);
        issue(STO, 4'd0, 4'd0, 4'd2, 32'h22,   2'd1, 2'd1, 32'd0);
        issue(STO, 4'd0, 4'd0, 4'd3, 32'h33,   2'd2, 2'd1, 32'd0);
        apply_reset(2);
        issue(FET, 4'd1, 4'd0, 4'd0, 32'd0,    2'd0, 2'd1, 32'd0);
        issue(FET, 4'd2, 4'd0, 4'd0, 32'd0,    2'd1, 2'd1, 32'd0);
        issue(FET, 4'd3, 4'd0, 4'd0, 32'd0,    2'd2, 2'd1, 32'd0);
        issue(FET, 4'd4, 4'd0, 4'd0, 32'd0,    2'd3, 2'd1, 32'd0);
        issue(FET, 4'd6, 4'd0, 4'd0, 32'd0,    2'd0, 2'd1, 32'd0);
        idle(8);

        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d outstanding responses, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/calc3_port_responder.md
# calc3_port_responder

Single-port calc3 request responder. It accepts requests on a `reqx_*` bundle and returns tagged responses on an `outx_*` bundle with fixed latency. It is the responding end of the per-port calc3 request/response protocol, and the verification team uses it as a reference model and stand-in for one `calc3_top` port. Internally it holds a 16 × 32-bit register file and a 3-stage response pipeline, and it tracks in-flight tags.

## Interface

- `LATENCY`, 3: cycles from request sample to response; legal range 2–8.
- `clk` in 1: single clock; everything samples on the rising edge.
- `reset` in 1: synchronous, active-low. Sampled only on the rising edge of `clk`.
- `reqx_cmd` in 4: command. 0 = none, 1 = add, 2 = sub, 5 = shift-left, 6 = shift-right, 12 = store, 13 = fetch. All other values are invalid.
- `reqx_data` in 32: store operand.
- `reqx_d1` in 4: first source register index.
- `reqx_d2` in 4: second source register index.
- `reqx_r1` in 4: destination register index.
- `reqx_tag` in 2: request tag, echoed on the response.
- `outx_resp` out 2: response code. 0 = none, 1 = success, 2 = error (overflow, underflow, invalid command, or busy tag). Code 3 is never driven.
- `outx_tag` out 2: tag of the responding request.
- `outx_data` out 32: result data.

## Operation

**Request acceptance**
- A request is any cycle with `reqx_cmd != 0`. One request may be accepted per cycle, and the responder never stalls.

**Execution**
- Execution completes in the sample cycle. The register file is read and written in that cycle, so back-to-back requests see each other's results in program order.
- add: `R[r1] = R[d1] + R[d2]`.
  - Carry out of bit 31 is an error: `R[r1]` is unchanged and data = 0.
  - Otherwise data = sum.
- sub: `R[r1] = R[d1] - R[d2]`, unsigned.
  - `R[d1] < R[d2]` is an error: `R[r1]` is unchanged and data = 0.
- shift-left / shift-right: `R[r1] = R[d1]` shifted logically by `R[d2][4:0]`.
  - The result is always success; data = result.
- store: `R[r1] = reqx_data`. Success; data = 0.
- fetch: data = `R[d1]`. Success; the register file is unchanged.
- invalid cmd: error, data = 0, no register write.
- When `r1` equals `d1` or `d2`, the sources are read before the write.

**Tag tracking**
- The `busy[3:0]` bit for a tag is set when a request with that tag is accepted while the bit is clear. Such a request is a "tagged slot".
- A request whose tag is already busy gets an error response (data = 0) and has no register effect. It does not modify `busy`.
- `busy[tag]` clears in the cycle its tagged slot's response is driven.
- If a new request with the same tag arrives in that same cycle, it sees busy = 0 and re-sets the bit (the set wins over the clear).

**Reset**
- While `reset` = 0 at an edge:
  - all registers clear to 0;
  - `busy` clears;
  - the pipeline flushes, and in-flight responses are dropped and never emitted;
  - requests presented in that cycle are ignored.

## Timing

- A request sampled at edge N drives its response from edge N + `LATENCY` until edge N + `LATENCY` + 1. `outx_*` is valid for exactly one cycle.
- All outputs are registered. In cycles with no response due, `outx_resp` = 0, `outx_tag` = 0, `outx_data` = 0.
- Reset values: `outx_resp` = 0, `outx_tag` = 0, `outx_data` = 0, all R = 0, `busy` = 0.
- The first request accepted after reset deassertion is the one sampled at the first edge with `reset` = 1.
- The pipeline holds at most `LATENCY` responses. Each slot carries {resp, tag, data, tagged flag}.
- Response order always equals request order.
- Continuous issue of 4 distinct tags at `LATENCY` = 3 never produces a busy error. A 5th distinct tag cannot exist, because tags wrap over 0–3.
- A tag is reusable at the edge where its response is driven (edge N + `LATENCY`). Reuse at any edge before that is an error.

## Test plan

- **Reset:** hold `reset` = 0 for 2 cycles, then fetch R5 with tag 1 → at N + 3, resp = 1, tag = 1, data = 0x0. No output activity during reset.
- **Store/add/overflow:**
  - store R1 = 0xFFFF_FFFF (tag 0), then store R2 = 0x1 (tag 1), then add R3 = R1 + R2 (tag 2), on consecutive cycles.
  - Required responses: 1/0/0, then 1/1/0, then 2/2/0.
  - A following fetch of R3 returns 0x0.
- **Sub and shifts:**
  - R4 = 10, R5 = 3.
  - sub R6 = R4 − R5 → 1, data 7.
  - sub R6 = R5 − R4 → 2, data 0, R6 stays 7.
  - shift-left R7 = R4 << R5 → data 80.
  - shift-right with R5 = 0x23 → shift by 3 → data 1.
- **Busy tag:**
  - Issue tag 2 at cycle N and again at N + 1 → responses at N + 3 (1) and N + 4 (2, no write).
  - Reissue tag 2 at N + 3 → accepted as success at N + 6.
- **Invalid command and back-to-back hazard:**
  - cmd 7 → resp 2, data 0.
  - Then store R1 = 5, immediately followed by add R1 = R1 + R1 → data 10.
- **Reset mid-operation:**
  - Issue 3 requests, then assert `reset` at the cycle after the last.
  - Required: no responses emerge, registers read 0 afterward, and all tags are immediately reusable.
